// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input and imem write-side bundle for the
//               instruction-memory bootloader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if;
  // Byte stream from the UART receiver
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  // Instruction-memory write port
  logic        o_we;
  logic [31:0] o_waddr;
  logic [31:0] o_wdata;
  // Status
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_load_ok;

  // Loader side: consumes bytes, produces writes and status
  modport slave (
    input  i_rx_valid, i_rx_data,
    output o_rx_ready, o_we, o_waddr, o_wdata,
    output o_busy, o_done, o_err, o_load_ok
  );

  // Byte source / memory / core-reset side
  modport master (
    output i_rx_valid, i_rx_data,
    input  o_rx_ready, o_we, o_waddr, o_wdata,
    input  o_busy, o_done, o_err, o_load_ok
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream bootloader. Parses frames of the form
//               A5 | count[15:0] LE | count x 32-bit LE words | XOR checksum
//               and streams the words into the instruction memory write port
//               while holding the core in reset via o_busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          N         = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  wire logic    i_clk,
  input  wire logic    i_reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0] N_MAX     = 32'(N);

  state_t        state_q;
  logic          rdy_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          load_ok_q;
  logic          we_q;
  logic [31:0]   waddr_q;
  logic [31:0]   wdata_q;
  logic [15:0]   cnt_q;      // word count of the current frame
  logic [15:0]   widx_q;     // index of the word being assembled
  logic [1:0]    bidx_q;     // byte lane of the next payload byte
  logic [23:0]   part_q;     // lower three bytes of the word in progress
  logic [7:0]    csum_q;     // running XOR of payload bytes
  logic [TW-1:0] tmo_q;      // idle cycles since the last accepted byte

  logic          fire;
  logic [15:0]   cnt_d;
  logic [23:0]   part_d;
  logic [7:0]    csum_d;
  logic [31:0]   waddr_d;

  // Byte handshake, lane insertion, checksum and write-address arithmetic
  always_comb begin
    fire    = bus.i_rx_valid & rdy_q;
    cnt_d   = {bus.i_rx_data, cnt_q[7:0]};
    csum_d  = csum_q ^ bus.i_rx_data;
    waddr_d = BASE_ADDR + {14'd0, widx_q, 2'b00};
    part_d  = part_q;
    case (bidx_q)
      2'd0:    part_d[7:0]   = bus.i_rx_data;
      2'd1:    part_d[15:8]  = bus.i_rx_data;
      2'd2:    part_d[23:16] = bus.i_rx_data;
      default: part_d        = part_q;
    endcase
  end

  // Frame parser FSM with registered strobes and status
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      load_ok_q <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      part_q    <= '0;
      csum_q    <= '0;
      tmo_q     <= '0;
    end else begin
      // Ready is permanently high once out of reset; strobes default low
      rdy_q  <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;

      if (!fire) begin
        // Inactivity inside a frame aborts it, dropping any partial word
        if (state_q != S_IDLE) begin
          if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
      end else begin
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            // Only the sync byte opens a frame; everything else is dropped
            if (bus.i_rx_data == SYNC_BYTE) begin
              state_q   <= S_LEN_LO;
              busy_q    <= 1'b1;
              load_ok_q <= 1'b0;
              csum_q    <= '0;
              bidx_q    <= '0;
              widx_q    <= '0;
            end
          end

          S_LEN_LO: begin
            cnt_q[7:0] <= bus.i_rx_data;
            state_q    <= S_LEN_HI;
          end

          S_LEN_HI: begin
            cnt_q[15:8] <= bus.i_rx_data;
            if ({16'd0, cnt_d} > N_MAX) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (cnt_d == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end

          S_DATA: begin
            csum_q <= csum_d;
            if (bidx_q == 2'd3) begin
              // Word complete: issue the write on the following cycle
              we_q    <= 1'b1;
              waddr_q <= waddr_d;
              wdata_q <= {bus.i_rx_data, part_q};
              bidx_q  <= '0;
              widx_q  <= widx_q + 16'd1;
              if (widx_q == cnt_q - 16'd1) begin
                state_q <= S_CSUM;
              end
            end else begin
              part_q <= part_d;
              bidx_q <= bidx_q + 2'd1;
            end
          end

          S_CSUM: begin
            if (bus.i_rx_data == csum_q) begin
              done_q    <= 1'b1;
              load_ok_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end

          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Drive the bundle from the registered state
  always_comb begin
    bus.o_rx_ready = rdy_q;
    bus.o_we       = we_q;
    bus.o_waddr    = waddr_q;
    bus.o_wdata    = wdata_q;
    bus.o_busy     = busy_q;
    bus.o_done     = done_q;
    bus.o_err      = err_q;
    bus.o_load_ok  = load_ok_q;
  end

endmodule

`default_nettype wire
